// File: rtl/uart_matrix_rx.sv
// -----------------------------------------------------------------------------
// uart_matrix_rx
//
// Receive side of the matrix link. Deserialises an 8N1-style UART line with W
// data bits, decodes two-character update packets (header, then data), and
// stores each decoded value in a local 2x4 cell matrix.
//
// Packet format:
//   header : bit W-1 = 1, bit 2 = row, bits 1:0 = column (bits W-2:3 ignored)
//   data   : any value; written to the cell addressed by the preceding header
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   rx         serial line, idle high, asynchronous to clk
//   row, col   read address for r_cell
//   r_cell     matrix[row][col], combinational read
//   r_busy     high while a character is being received
//   upd_valid  one-cycle pulse in the cycle before the addressed cell updates
//   frame_err  one-cycle pulse on a bad stop bit or an orphan data character
// -----------------------------------------------------------------------------
module uart_matrix_rx #(
   parameter int W            = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         rx,
   input  logic         row,
   input  logic [1:0]   col,
   output logic [W-1:0] r_cell,
   output logic         r_busy,
   output logic         upd_valid,
   output logic         frame_err
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W = $clog2(W);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(W - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_e;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [IDX_W-1:0] idx_q;
   logic [W-1:0]     shift_q;
   logic             rx_meta_q;
   logic             rx_s_q;
   logic             armed_q;     // a 1 has been seen since the last bad stop / reset
   logic             hdr_q;       // header accepted, waiting for its data character
   logic             addr_row_q;
   logic [1:0]       addr_col_q;
   logic [W-1:0]     wdata_q;
   logic             busy_q;
   logic             upd_q;
   logic             ferr_q;
   logic [W-1:0]     cells_q [2][4];

   // Two-flop synchroniser; resets to the idle level so reset release never
   // looks like a start bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // Character FSM and packet decoder. All outputs are registered here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         shift_q    <= '0;
         armed_q    <= 1'b0;
         hdr_q      <= 1'b0;
         addr_row_q <= 1'b0;
         addr_col_q <= '0;
         wdata_q    <= '0;
         busy_q     <= 1'b0;
         upd_q      <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         // NOTE: strobes default low every cycle so each one is a single-cycle pulse.
         upd_q  <= 1'b0;
         ferr_q <= 1'b0;

         unique case (state_q)
            IDLE: begin
               if (!armed_q) begin
                  // After a break or reset the line must go high before a
                  // falling edge counts as a start bit.
                  if (rx_s_q) armed_q <= 1'b1;
               end else if (!rx_s_q) begin
                  state_q <= START;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end

            START: begin
               if (cnt_q == HALF_LAST) begin
                  cnt_q <= '0;
                  if (rx_s_q) begin
                     // Line back high at mid start bit: glitch, not a character.
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= DATA;
                     idx_q   <= '0;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            DATA: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q   <= '0;
                  shift_q <= {rx_s_q, shift_q[W-1:1]};   // LSB arrives first
                  if (idx_q == IDX_LAST) state_q <= STOP;
                  else                   idx_q   <= idx_q + 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            STOP: begin
               if (cnt_q == BIT_LAST) begin
                  // Leave at the stop-bit centre so an immediately following
                  // start bit is still seen.
                  cnt_q   <= '0;
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  if (rx_s_q) begin
                     armed_q <= 1'b1;
                     if (hdr_q) begin
                        wdata_q <= shift_q;
                        upd_q   <= 1'b1;
                        hdr_q   <= 1'b0;
                     end else if (shift_q[W-1]) begin
                        addr_row_q <= shift_q[2];
                        addr_col_q <= shift_q[1:0];
                        hdr_q      <= 1'b1;
                     end else begin
                        ferr_q <= 1'b1;              // data with no header
                     end
                  end else begin
                     armed_q <= 1'b0;
                     hdr_q   <= 1'b0;
                     ferr_q  <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   // Cell storage: written the cycle after the stop sample, while upd_valid is high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the matrix is architecturally cleared by reset, so it is built
         // from resettable flops rather than a RAM.
         for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
               cells_q[r][c] <= '0;
            end
         end
      end else if (upd_q) begin
         cells_q[addr_row_q][addr_col_q] <= wdata_q;
      end
   end

   assign r_cell    = cells_q[row][col];
   assign r_busy    = busy_q;
   assign upd_valid = upd_q;
   assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_matrix_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_matrix_rx
//
// Directed bench for uart_matrix_rx (W=8, CLKS_PER_BIT=4). Stimulus changes on
// the falling clock edge; outputs are sampled 1 ns after a falling edge.
// -----------------------------------------------------------------------------
module tb_uart_matrix_rx;

   localparam int W   = 8;
   localparam int CPB = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         rx;
   logic         row;
   logic [1:0]   col;
   logic [W-1:0] r_cell;
   logic         r_busy;
   logic         upd_valid;
   logic         frame_err;

   uart_matrix_rx #(.W(W), .CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .row       (row),
      .col       (col),
      .r_cell    (r_cell),
      .r_busy    (r_busy),
      .upd_valid (upd_valid),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   logic [W-1:0] exp_cells [2][4];

   // Pulse and busy-run monitors, sampled on the falling edge.
   int upd_total = 0;
   int ferr_total = 0;
   int busy_run = 0;
   int last_run = 0;

   always @(negedge clk) begin
      if (upd_valid === 1'b1) upd_total++;
      if (frame_err === 1'b1) ferr_total++;
      if (r_busy === 1'b1) begin
         busy_run++;
      end else begin
         if (busy_run != 0) last_run = busy_run;
         busy_run = 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic settle();
      cycles(6);
      #1;
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      cycles(CPB);
   endtask

   task automatic send_char(input logic [7:0] c, input logic stop_bit);
      send_bit(1'b0);
      for (int i = 0; i < W; i++) send_bit(c[i]);
      send_bit(stop_bit);
   endtask

   task automatic send_pkt(input logic [7:0] h, input logic [7:0] d);
      send_char(h, 1'b1);
      send_char(d, 1'b1);
   endtask

   task automatic clear_model();
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 4; c++)
            exp_cells[r][c] = '0;
   endtask

   task automatic check_matrix(input string tag);
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < 4; c++) begin
            row = 1'(r);
            col = 2'(c);
            #1;
            check($sformatf("%s cell[%0d][%0d]", tag, r, c), 32'(r_cell), 32'(exp_cells[r][c]));
         end
      end
   endtask

   initial begin
      int u0;
      int f0;

      rst = 1'b0;
      rx  = 1'b1;
      row = 1'b0;
      col = 2'd0;
      clear_model();

      // Reset held with the line toggling: nothing may happen.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         rx = ~rx;
         #1;
         check($sformatf("reset outputs %0d", i), 32'({r_busy, upd_valid, frame_err}), 32'd0);
      end
      check_matrix("reset");

      // Release with idle line.
      rx = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      u0 = upd_total;
      f0 = ferr_total;
      cycles(20);
      #1;
      check("idle busy", 32'(r_busy), 32'd0);
      check("idle upd count", 32'(upd_total - u0), 32'd0);
      check("idle ferr count", 32'(ferr_total - f0), 32'd0);

      // Single update: header 0x87 (row 1, col 3), data 0x08.
      u0 = upd_total;
      f0 = ferr_total;
      send_pkt(8'h87, 8'h08);
      settle();
      exp_cells[1][3] = 8'h08;
      check("single upd count", 32'(upd_total - u0), 32'd1);
      check("single ferr count", 32'(ferr_total - f0), 32'd0);
      check("single busy length", 32'(last_run >= 36 && last_run <= 40), 32'd1);
      check_matrix("single");

      // Row burst, back to back.
      u0 = upd_total;
      f0 = ferr_total;
      send_pkt(8'h80, 8'h01);
      send_pkt(8'h81, 8'h02);
      send_pkt(8'h82, 8'h03);
      send_pkt(8'h83, 8'h04);
      settle();
      exp_cells[0][0] = 8'h01;
      exp_cells[0][1] = 8'h02;
      exp_cells[0][2] = 8'h03;
      exp_cells[0][3] = 8'h04;
      check("burst upd count", 32'(upd_total - u0), 32'd4);
      check("burst ferr count", 32'(ferr_total - f0), 32'd0);
      check_matrix("burst");

      // Data characters with and without MSB set.
      u0 = upd_total;
      f0 = ferr_total;
      send_pkt(8'h86, 8'hAA);
      send_pkt(8'h82, 8'h55);
      settle();
      exp_cells[1][2] = 8'hAA;
      exp_cells[0][2] = 8'h55;
      check("msb upd count", 32'(upd_total - u0), 32'd2);
      check("msb ferr count", 32'(ferr_total - f0), 32'd0);
      check_matrix("msb");

      // Header with a bad stop bit, then an orphan data character.
      u0 = upd_total;
      f0 = ferr_total;
      send_char(8'h84, 1'b0);
      rx = 1'b1;
      settle();
      check("bad stop ferr count", 32'(ferr_total - f0), 32'd1);
      check("bad stop upd count", 32'(upd_total - u0), 32'd0);
      send_char(8'h05, 1'b1);
      settle();
      check("orphan ferr count", 32'(ferr_total - f0), 32'd2);
      check("orphan upd count", 32'(upd_total - u0), 32'd0);
      send_pkt(8'h80, 8'h11);
      settle();
      exp_cells[0][0] = 8'h11;
      check("recover upd count", 32'(upd_total - u0), 32'd1);
      check("recover ferr count", 32'(ferr_total - f0), 32'd2);
      check_matrix("recover");

      // Break: one zero character with frame_err, then no re-trigger while low.
      u0 = upd_total;
      f0 = ferr_total;
      rx = 1'b0;
      cycles(120);
      #1;
      check("break ferr count", 32'(ferr_total - f0), 32'd1);
      check("break busy", 32'(r_busy), 32'd0);
      rx = 1'b1;
      cycles(10);
      send_pkt(8'h81, 8'h77);
      settle();
      exp_cells[0][1] = 8'h77;
      check("after break upd count", 32'(upd_total - u0), 32'd1);
      check_matrix("after break");

      // One-cycle glitch: short busy, no error, no write.
      u0 = upd_total;
      f0 = ferr_total;
      @(negedge clk);
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      cycles(20);
      #1;
      check("glitch busy length", 32'(last_run >= 1 && last_run <= 3), 32'd1);
      check("glitch busy", 32'(r_busy), 32'd0);
      check("glitch ferr count", 32'(ferr_total - f0), 32'd0);
      check("glitch upd count", 32'(upd_total - u0), 32'd0);

      // Reset in the middle of a data bit.
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      cycles(1);
      #1;
      check("mid char busy", 32'(r_busy), 32'd1);
      rst = 1'b0;
      #1;
      check("async reset busy", 32'(r_busy), 32'd0);
      clear_model();
      check_matrix("mid reset");
      rx = 1'b1;
      cycles(3);
      rst = 1'b1;
      cycles(10);
      u0 = upd_total;
      f0 = ferr_total;
      send_pkt(8'h85, 8'h3C);
      settle();
      exp_cells[1][1] = 8'h3C;
      check("post reset upd count", 32'(upd_total - u0), 32'd1);
      check("post reset ferr count", 32'(ferr_total - f0), 32'd0);
      check_matrix("post reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_matrix_rx.md
Name: uart_matrix_rx

Overview:
- Receive-side stage directly downstream of the matrix transmitter.
- Deserializes the UART line (8N1-style, W data bits) and decodes two-character update packets (header, then data).
- Writes each decoded value into a local 2x4 cell matrix.
- Exposes the matrix through a combinational cell-read port (r_cell), plus busy and status strobes.

Parameters:
- W, 8, data bits per character and cell width; W >= 4.
- CLKS_PER_BIT, 4, clock cycles per serial bit; even, >= 4.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- rx  input  1  serial line; idle high, asynchronous to clk.
- row  input  1  read row select for r_cell.
- col  input  2  read column select for r_cell.
- r_cell  output  W  matrix[row][col], combinational read.
- r_busy  output  1  high while a character is being received.
- upd_valid  output  1  one-cycle pulse when a matrix cell is written.
- frame_err  output  1  one-cycle pulse on a bad stop bit or an orphan data character.

Behaviour:
- Reset (rst=0, async):
  - All 8 cells = 0; state = IDLE.
  - r_busy = 0, upd_valid = 0, frame_err = 0.
  - Header flag cleared; rx synchronizer flops = 1.
- Input sync: rx passes through 2 flops (rx_s); all decoding uses rx_s, adding 2 cycles of latency.
- Character FSM, counter cnt, bit index idx:
  - IDLE: rx_s=0 -> START, cnt=0, r_busy=1.
  - START: after CLKS_PER_BIT/2 cycles, sample rx_s.
    - rx_s=1 -> false start; back to IDLE, r_busy=0, no error.
    - rx_s=0 -> DATA, idx=0.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into bit idx (LSB first). After bit W-1 -> STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s and go to IDLE; r_busy=0 on the same edge.
    - rx_s=1 -> character accepted.
    - rx_s=0 -> frame_err pulse; character discarded; header flag cleared.
  - Return to IDLE happens at the stop-bit centre, so a start bit arriving half a bit later is still caught.
- Packet decode, on an accepted character c:
  - Header flag clear, c[W-1]=1 -> header:
    - latch addr_row = c[2], addr_col = c[1:0]; set header flag.
    - c[W-2:3] are ignored.
  - Header flag clear, c[W-1]=0 -> orphan: frame_err pulse; character dropped.
  - Header flag set -> data, whatever c[W-1] is:
    - matrix[addr_row][addr_col] = c; header flag cleared.
    - upd_valid pulse on the write cycle.
- Write timing: the cell is written one clock after the STOP sample edge, and upd_valid is high in that cycle. r_cell shows the new value from the following cycle when the address matches.
- Read port: r_cell is a pure mux of the matrix on row/col; no read latency, no side effects.
- A sustained low line (break) yields a character of zeros with frame_err, then waits for rx_s to return to 1 before re-arming.
  - Re-arm mechanism: IDLE requires a 1 seen since the last STOP before accepting a new start.
- Mid-operation reset: aborts the character and clears the header flag and matrix. After release, the receiver needs rx_s=1 for at least one cycle before detecting a start.
- Sequential cell updates are independent: a new packet may start immediately after the previous data character's stop bit.

Test Plan:
- Reset:
  - Hold rst=0 with rx toggling -> all r_cell reads = 0; r_busy, upd_valid and frame_err stay 0.
  - Release rst -> no spurious activity while rx=1.
- Single update:
  - Send header 0x87 (row1, col3), then data 0x08, CLKS_PER_BIT=4 -> one upd_valid pulse.
  - r_cell at row=1, col=3 reads 8; the other 7 cells read 0.
  - r_busy is high for about 10*4 cycles per character.
- Row burst:
  - Send four back-to-back packets (0x80,1), (0x81,2), (0x82,3), (0x83,4) with no idle gap -> four upd_valid pulses.
  - Row 0 reads 1,2,3,4; row 1 is unchanged.
- Data with MSB set:
  - Header 0x86, data 0xAA -> cell[1][2] = 170.
  - Then header 0x82, data 0x55 -> cell[0][2] = 85.
  - No frame_err in either packet.
- Errors:
  - Header whose stop bit is 0 -> frame_err, no write.
  - A following lone 0x05 -> second frame_err (orphan).
  - Then a valid packet (0x80, 0x11) -> cell[0][0] = 0x11.
- Glitch and reset:
  - A 1-cycle low pulse on rx -> no r_busy beyond START, no error.
  - Assert rst during a DATA bit -> immediate IDLE, matrix cleared.
  - Next full packet decodes correctly.
